bram_port_arbiter: RTL
======================

Name: bram_port_arbiter

Overview:
- Shares one 256x16 iCE40 block RAM (SB_RAM40_4K, WRITE_MODE=READ_MODE=0) between two requesters, e.g. CPU data port (req0) and a DMA/debug loader (req1).
- Runs a round-robin arbiter with a valid/ready request handshake and routes registered read data back to the owning requester.
- Optionally clears the whole RAM after reset.
- Sits between the requesters and a single SB_RAM40_4K instance; RCLK = WCLK = clk.

Parameters:
- ADDR_W, 8, word address width; RAM depth = 2**ADDR_W (max 8).
- CLEAR_ON_RESET, 1, 1 = sweep all words with CLEAR_VALUE after reset; 0 = serve immediately.
- CLEAR_VALUE, 16'h0000, data written during the clear sweep.
- PRIO_START, 0, requester that wins the first tie after reset.

Ports:
- clk  in  1  single clock; also drives RAM RCLK/WCLK.
- rst  in  1  synchronous, active-high reset.
- reqN_valid  in  1  (N = 0,1) request present.
- reqN_ready  out  1  request accepted this cycle when valid & ready.
- reqN_we  in  1  1 = write, 0 = read.
- reqN_addr  in  ADDR_W  word address.
- reqN_wdata  in  16  write data.
- reqN_be  in  2  active-high byte enables: [0] = bits 7:0, [1] = bits 15:8.
- rspN_valid  out  1  one-cycle read-data strobe.
- rspN_rdata  out  16  read data, valid only while rspN_valid.
- busy  out  1  clear sweep in progress.
- ram_re, ram_rclke  out  1  RAM read enable / read clock enable.
- ram_we, ram_wclke  out  1  RAM write enable / write clock enable.
- ram_raddr  out  11  RAM read address.
- ram_waddr  out  11  RAM write address.
- ram_wdata  out  16  RAM write data.
- ram_mask  out  16  RAM write mask; 1 = bit NOT written.
- ram_rdata  in  16  registered RAM read data.

Behaviour:
- States: CLEAR, SERVE.
  - Reset enters CLEAR if CLEAR_ON_RESET, else SERVE.
  - rst asserted at any time, including mid-sweep, restarts from the reset state with the clear address at 0.
- CLEAR:
  - Per cycle: ram_we = ram_wclke = 1, ram_waddr = clr_addr, ram_mask = 0, ram_wdata = CLEAR_VALUE.
  - clr_addr increments from 0 to 2**ADDR_W-1, then the state moves to SERVE. Sweep is exactly 2**ADDR_W cycles.
  - busy = 1 throughout, both ready = 0, all requests ignored.
  - busy falls in the first SERVE cycle.
- SERVE ready rules (ready is independent of own valid):
  - ready0 = ~valid1 | last == 1.
  - ready1 = ~valid0 | last == 0.
  - At most one acceptance per cycle; a lone valid is always granted.
- Arbitration state:
  - last resets to ~PRIO_START.
  - last updates only on an acceptance. Idle cycles and cycles with valid but no acceptance leave it unchanged.
  - Two continuously valid requesters alternate grants every cycle.
- Accepted write:
  - Same cycle: ram_we = ram_wclke = 1, ram_waddr = {0, addr}.
  - ram_wdata = wdata, ram_mask = ~{{8{be[1]}},{8{be[0]}}}.
  - be = 0 is a legal no-op write that still consumes a grant.
  - No response is generated.
- Accepted read:
  - Same cycle: ram_re = ram_rclke = 1, ram_raddr = {0, addr}.
  - owner and pending registered.
  - Next cycle: rsp<owner>_valid = 1 for exactly one cycle, rsp<owner>_rdata = ram_rdata. Latency is 1 cycle.
  - Back-to-back reads give back-to-back responses.
- Ordering:
  - Write at cycle t followed by a read of the same address at t+1 (either requester) returns the new data.
  - A read accepted in the cycle of a rst is discarded.
- Idle: RAM enables 0, addresses/wdata 0, ram_mask = 16'hFFFF.
- Reset values: ready 0 (CLEAR) or per the rules above (no CLEAR), rspN_valid 0, rspN_rdata 0, busy = CLEAR_ON_RESET, pending 0.
- rspN_rdata is zero when rspN_valid is 0 (gated) so consumers see no stale data.

Decomposition:
- Package bram_arb_pkg holds:
  - state enum {CLEAR, SERVE};
  - RAM_DW = 16 and RAM_AW = 11;
  - function be_to_mask(be) returning the 16-bit active-low-write mask.
- Sub-module rr_arbiter2: 2-way round-robin with the last-grant register, inputs valid[1:0]/accept, output grant[1:0]; instantiated once.

Test Plan:
- Clear sweep: CLEAR_ON_RESET=1, CLEAR_VALUE=16'hA5A5, release rst -> busy high exactly 256 cycles, ram_waddr 0..255 with mask 0. A read of addr 8'h37 afterwards returns 16'hA5A5 with rsp0_valid one cycle after accept.
- Byte enables: req0 writes 16'h1234 be=2'b11 to addr 5, then 16'hAB00 be=2'b10, then reads addr 5 -> ram_mask 16'h0000 then 16'h00FF; read returns 16'hAB34.
- Contention: both valid every cycle for 6 cycles with PRIO_START=0, req0 reads addr 1, req1 reads addr 2 -> grants 0,1,0,1,0,1. rsp0/rsp1 alternate one cycle later with the correct data, never both high.
- Write-then-read: req1 writes 16'hBEEF to addr 9 at t, req0 reads addr 9 at t+1 -> rsp0_rdata = 16'hBEEF at t+2.
- Reset mid-sweep: assert rst at clear address 100 -> sweep restarts at 0, busy high a further 256 cycles. rst during a pending read -> no rspN_valid.
- No-clear mode: CLEAR_ON_RESET=0 -> busy 0 and req0_ready 1 in the first cycle after reset. A lone req1 request is granted even when last == 1.

Source files
------------

// File: rtl/bram_arb_pkg.sv
// Shared types, widths and the byte-enable to RAM write-mask helper for the
// two-requester block-RAM arbiter.
package bram_arb_pkg;
  typedef enum logic {CLEAR, SERVE} state_t;

  localparam int RAM_DW = 16;
  localparam int RAM_AW = 11;

  // The RAM mask is active-low-write: a set bit keeps the stored bit.
  function automatic logic [RAM_DW-1:0] be_to_mask(input logic [1:0] be);
    return ~{{8{be[1]}}, {8{be[0]}}};
  endfunction
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: a lone request always wins, a tie goes to the
// requester that was not granted last. Grants are offers, independent of own valid.
module rr_arbiter2 #(
  parameter int PRIO_START = 0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_valid,
  input  logic       i_accept,
  output logic [1:0] o_grant
);
  logic       r_last;
  logic [1:0] w_win;

  assign o_grant[0] = ~i_valid[1] | r_last;
  assign o_grant[1] = ~i_valid[0] | ~r_last;
  assign w_win      = i_valid & o_grant & {2{i_accept}};

  // Only a real acceptance moves the round-robin pointer.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last <= (PRIO_START == 0);
    end else if (w_win[0]) begin
      r_last <= 1'b0;
    end else if (w_win[1]) begin
      r_last <= 1'b1;
    end
  end
endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one 256x16 SB_RAM40_4K between two valid/ready requesters, with an
// optional post-reset clear sweep; reads return one cycle after acceptance.
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int          ADDR_W         = 8,
  parameter bit          CLEAR_ON_RESET = 1'b1,
  parameter logic [15:0] CLEAR_VALUE    = 16'h0000,
  parameter int          PRIO_START     = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [15:0]       req0_wdata,
  input  logic [1:0]        req0_be,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [15:0]       req1_wdata,
  input  logic [1:0]        req1_be,
  output logic              rsp0_valid,
  output logic [15:0]       rsp0_rdata,
  output logic              rsp1_valid,
  output logic [15:0]       rsp1_rdata,
  output logic              busy,
  output logic              ram_re,
  output logic              ram_rclke,
  output logic              ram_we,
  output logic              ram_wclke,
  output logic [10:0]       ram_raddr,
  output logic [10:0]       ram_waddr,
  output logic [15:0]       ram_wdata,
  output logic [15:0]       ram_mask,
  input  logic [15:0]       ram_rdata
);
  state_t            r_state;
  logic [ADDR_W-1:0] r_clr_addr;
  logic              r_pend;
  logic              r_owner;

  logic              w_serve;
  logic [1:0]        w_valid;
  logic [1:0]        w_grant;
  logic [1:0]        w_acc;
  logic              w_any;
  logic              w_sel;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [15:0]       w_wdata;
  logic [1:0]        w_be;

  assign w_serve = (r_state == SERVE);
  assign w_valid = {req1_valid, req0_valid};
  assign busy    = (r_state == CLEAR);

  rr_arbiter2 #(.PRIO_START(PRIO_START)) u_arb (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_valid  (w_valid),
    .i_accept (w_serve),
    .o_grant  (w_grant)
  );

  assign req0_ready = w_serve & w_grant[0];
  assign req1_ready = w_serve & w_grant[1];
  assign w_acc      = w_valid & {req1_ready, req0_ready};
  assign w_any      = |w_acc;
  assign w_sel      = w_acc[1];
  assign w_we       = w_sel ? req1_we    : req0_we;
  assign w_addr     = w_sel ? req1_addr  : req0_addr;
  assign w_wdata    = w_sel ? req1_wdata : req0_wdata;
  assign w_be       = w_sel ? req1_be    : req0_be;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= CLEAR_ON_RESET ? CLEAR : SERVE;
      r_clr_addr <= '0;
      r_pend     <= 1'b0;
      r_owner    <= 1'b0;
    end else begin
      if (r_state == CLEAR) begin
        r_clr_addr <= r_clr_addr + ADDR_W'(1);
        if (&r_clr_addr) r_state <= SERVE;
      end
      r_pend <= w_any & ~w_we;
      if (w_any & ~w_we) r_owner <= w_sel;
    end
  end

  // Read data is gated so an idle response port never shows stale RAM output.
  assign rsp0_valid = r_pend & ~r_owner;
  assign rsp1_valid = r_pend & r_owner;
  assign rsp0_rdata = rsp0_valid ? ram_rdata : 16'h0000;
  assign rsp1_rdata = rsp1_valid ? ram_rdata : 16'h0000;

  always_comb begin
    ram_we    = 1'b0;
    ram_wclke = 1'b0;
    ram_re    = 1'b0;
    ram_rclke = 1'b0;
    ram_waddr = '0;
    ram_raddr = '0;
    ram_wdata = '0;
    ram_mask  = '1;
    if (r_state == CLEAR) begin
      ram_we    = 1'b1;
      ram_wclke = 1'b1;
      ram_waddr = RAM_AW'(r_clr_addr);
      ram_wdata = CLEAR_VALUE;
      ram_mask  = '0;
    end else if (w_any) begin
      if (w_we) begin
        ram_we    = 1'b1;
        ram_wclke = 1'b1;
        ram_waddr = RAM_AW'(w_addr);
        ram_wdata = w_wdata;
        ram_mask  = be_to_mask(w_be);
      end else begin
        ram_re    = 1'b1;
        ram_rclke = 1'b1;
        ram_raddr = RAM_AW'(w_addr);
      end
    end
  end
endmodule
